// File: rtl/alu_share_arbiter.sv
// Round-robin front end that lets two requesters share one 16-bit ALU.
// Operands are registered and held for the op's execute time. The result is then returned under a valid/ready handshake.
module alu_share_arbiter #(
  parameter int unsigned MUL_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [2:0]  req0_op,
  input  logic [15:0] req0_a,
  input  logic [15:0] req0_b,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [2:0]  req1_op,
  input  logic [15:0] req1_a,
  input  logic [15:0] req1_b,
  output logic [15:0] alu_in1,
  output logic [15:0] alu_in2,
  output logic [2:0]  alu_control,
  input  logic [15:0] alu_res,
  input  logic        zero,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [15:0] rsp_res,
  output logic        rsp_zero,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [2:0] OP_MUL   = 3'b101;
  localparam logic [3:0] MUL_LOAD = 4'(MUL_CYCLES - 1);

  state_t      state_q, state_d;
  logic        last_grant_q, last_grant_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] alu_in1_q, alu_in1_d;
  logic [15:0] alu_in2_q, alu_in2_d;
  logic [2:0]  alu_control_q, alu_control_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_id_q, rsp_id_d;
  logic [15:0] rsp_res_q, rsp_res_d;
  logic        rsp_zero_q, rsp_zero_d;

  logic        grant;
  logic        accept;
  logic [2:0]  sel_op;
  logic [15:0] sel_a;
  logic [15:0] sel_b;

  // On a conflict, the port that did not win last time gets the grant.
  always_comb begin
    grant = 1'b0;
    if (req0_valid && req1_valid) begin
      grant = ~last_grant_q;
    end else if (req1_valid) begin
      grant = 1'b1;
    end
  end

  assign accept     = (state_q == IDLE) && (req0_valid || req1_valid);
  assign req0_ready = accept && !grant;
  assign req1_ready = accept && grant;

  assign sel_op = grant ? req1_op : req0_op;
  assign sel_a  = grant ? req1_a  : req0_a;
  assign sel_b  = grant ? req1_b  : req0_b;

  always_comb begin
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    cnt_d         = cnt_q;
    alu_in1_d     = alu_in1_q;
    alu_in2_d     = alu_in2_q;
    alu_control_d = alu_control_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_id_d      = rsp_id_q;
    rsp_res_d     = rsp_res_q;
    rsp_zero_d    = rsp_zero_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          alu_in1_d     = sel_a;
          alu_in2_d     = sel_b;
          alu_control_d = sel_op;
          rsp_id_d      = grant;
          last_grant_d  = grant;
          cnt_d         = (sel_op == OP_MUL) ? MUL_LOAD : 4'd0;
          state_d       = EXEC;
        end
      end
      EXEC: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          rsp_res_d   = alu_res;
          rsp_zero_d  = zero;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // last_grant resets to 1 so that port 0 wins the first conflict.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      last_grant_q  <= 1'b1;
      cnt_q         <= 4'd0;
      alu_in1_q     <= 16'd0;
      alu_in2_q     <= 16'd0;
      alu_control_q <= 3'b000;
      rsp_valid_q   <= 1'b0;
      rsp_id_q      <= 1'b0;
      rsp_res_q     <= 16'd0;
      rsp_zero_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_grant_q  <= last_grant_d;
      cnt_q         <= cnt_d;
      alu_in1_q     <= alu_in1_d;
      alu_in2_q     <= alu_in2_d;
      alu_control_q <= alu_control_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_id_q      <= rsp_id_d;
      rsp_res_q     <= rsp_res_d;
      rsp_zero_q    <= rsp_zero_d;
    end
  end

  assign alu_in1     = alu_in1_q;
  assign alu_in2     = alu_in2_q;
  assign alu_control = alu_control_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_id      = rsp_id_q;
  assign rsp_res     = rsp_res_q;
  assign rsp_zero    = rsp_zero_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Testbench for alu_share_arbiter: directed scenarios followed by random traffic.
// Each response is compared against a transaction-level model of arbitration and the ALU.
module tb_alu_share_arbiter;

  localparam int MUL = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [2:0]  req0_op, req1_op, alu_control;
  logic [15:0] req0_a, req0_b, req1_a, req1_b;
  logic [15:0] alu_in1, alu_in2, alu_res, rsp_res;
  logic        zero, rsp_valid, rsp_ready, rsp_id, rsp_zero, busy;

  int passed = 0;
  int total = 0;
  int lastGrant = 1;

  always #5 clk = ~clk;

  alu_share_arbiter #(.MUL_CYCLES(MUL)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_control(alu_control),
    .alu_res(alu_res), .zero(zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_res(rsp_res), .rsp_zero(rsp_zero), .busy(busy)
  );

  // Behavioural ALU; ops 110 and 111 fall through to add
  function automatic logic [15:0] aluRef(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    case (op)
      3'b000:  return a + b;
      3'b001:  return a - b;
      3'b010:  return a & b;
      3'b011:  return a | b;
      3'b100:  return (a < b) ? 16'd1 : 16'd0;
      3'b101:  return 16'((32'(a) * 32'(b)) % 65536);
      default: return a + b;
    endcase
  endfunction

  assign alu_res = aluRef(alu_control, alu_in1, alu_in2);
  assign zero    = (alu_res == 16'd0);

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int expGrant();
    if (req0_valid && req1_valid) return 1 - lastGrant;
    if (req1_valid) return 1;
    return 0;
  endfunction

  function automatic logic [1:0] expReady();
    if (!req0_valid && !req1_valid) return 2'b00;
    return (expGrant() == 1) ? 2'b10 : 2'b01;
  endfunction

  task automatic applyStimulus(input int port, input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    if (port == 0) begin
      req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b;
    end else begin
      req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b;
    end
  endtask

  // Called at a negedge with requests already driven; runs one full transaction
  task automatic serveOne(input string tag, input bit keepValid, input int bpCycles,
                          output int polls, output int gotPort);
    logic [2:0]  eop;
    logic [15:0] ea, eb, eres;
    int          lat;
    bit          found;
    found = 0; polls = 0; gotPort = -1;
    for (int i = 0; i < 30 && !found; i++) begin
      #1;
      if (req0_ready || req1_ready) begin
        found = 1;
        gotPort = req1_ready ? 1 : 0;
      end else begin
        polls++;
        @(negedge clk);
      end
    end
    if (!found) begin
      checkOutput({tag, "_grant_timeout"}, 0, 1);
      return;
    end
    checkOutput({tag, "_grant"}, gotPort, expGrant());
    checkOutput({tag, "_ready_excl"}, {31'd0, req0_ready & req1_ready}, 0);
    eop  = (gotPort == 1) ? req1_op : req0_op;
    ea   = (gotPort == 1) ? req1_a  : req0_a;
    eb   = (gotPort == 1) ? req1_b  : req0_b;
    eres = aluRef(eop, ea, eb);
    @(posedge clk);
    lastGrant = gotPort;
    #1;
    if (!keepValid) begin
      if (gotPort == 1) req1_valid = 1'b0;
      else req0_valid = 1'b0;
    end
    checkOutput({tag, "_busy_exec"}, {31'd0, busy}, 1);
    checkOutput({tag, "_no_ready_exec"}, {30'd0, req1_ready, req0_ready}, 0);
    checkOutput({tag, "_alu_in"}, {alu_control, alu_in1, alu_in2[12:0]}, {eop, ea, eb[12:0]});
    lat = 0; found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(posedge clk);
      lat++;
      #1;
      if (rsp_valid) found = 1;
      else checkOutput({tag, "_alu_hold"}, {13'd0, alu_control, alu_in1}, {13'd0, eop, ea});
    end
    checkOutput({tag, "_latency"}, lat, (eop == 3'b101) ? MUL : 1);
    checkOutput({tag, "_rsp_res"}, {16'd0, rsp_res}, {16'd0, eres});
    checkOutput({tag, "_rsp_zero"}, {31'd0, rsp_zero}, {31'd0, eres == 16'd0});
    checkOutput({tag, "_rsp_id"}, {31'd0, rsp_id}, gotPort);
    for (int k = 0; k < bpCycles; k++) begin
      @(posedge clk);
      #1;
      checkOutput({tag, "_bp_rsp"}, {13'd0, rsp_valid, rsp_id, rsp_zero, rsp_res},
                  {13'd0, 1'b1, gotPort[0], eres == 16'd0, eres});
      checkOutput({tag, "_bp_state"}, {29'd0, busy, req1_ready, req0_ready}, 32'd4);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    checkOutput({tag, "_rsp_clear"}, {30'd0, rsp_valid, busy}, 0);
    checkOutput({tag, "_next_ready"}, {30'd0, req1_ready, req0_ready}, {30'd0, expReady()});
    @(negedge clk);
  endtask

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int polls, port;
    reset = 1'b1; rsp_ready = 1'b1;
    req0_valid = 1'b0; req0_op = 3'b0; req0_a = 16'd0; req0_b = 16'd0;
    req1_valid = 1'b0; req1_op = 3'b0; req1_a = 16'd0; req1_b = 16'd0;
    #12;
    checkOutput("reset_ctrl", {28'd0, busy, rsp_valid, rsp_id, rsp_zero}, 0);
    checkOutput("reset_res", {16'd0, rsp_res}, 0);
    checkOutput("reset_alu", {13'd0, alu_control, alu_in1}, 0);
    checkOutput("reset_alu2", {16'd0, alu_in2}, 0);
    @(negedge clk); reset = 1'b0;
    @(negedge clk);

    // Both ports request continuously: grants alternate starting with port 0
    applyStimulus(0, 3'b001, 16'd3, 16'd3);
    applyStimulus(1, 3'b100, 16'd2, 16'd9);
    for (int k = 0; k < 4; k++) begin
      serveOne("conflict", 1'b1, 0, polls, port);
      checkOutput("conflict_order", port, k % 2);
      checkOutput("conflict_interval", polls, 0);
      checkOutput("conflict_res", {15'd0, rsp_zero, rsp_res}, (k % 2 == 0) ? 32'h10000 : 32'h00001);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;

    applyStimulus(0, 3'b000, 16'd7, 16'd5);
    serveOne("single", 1'b0, 0, polls, port);
    checkOutput("single_first_cycle", polls, 0);
    checkOutput("single_res", {16'd0, rsp_res}, 12);

    applyStimulus(1, 3'b101, 16'd300, 16'd300);
    serveOne("mul", 1'b0, 0, polls, port);
    checkOutput("mul_res", {16'd0, rsp_res}, 32'h5F90);

    applyStimulus(0, 3'b111, 16'd1, 16'd1);
    serveOne("op111", 1'b0, 0, polls, port);
    checkOutput("op111_ctrl_res", {13'd0, alu_control, rsp_res}, {13'd0, 3'b111, 16'd2});

    applyStimulus(0, 3'b010, 16'hF0F0, 16'h0FF0);
    applyStimulus(1, 3'b011, 16'h1200, 16'h0034);
    rsp_ready = 1'b0;
    serveOne("backpressure", 1'b0, 5, polls, port);
    serveOne("bp_pending", 1'b0, 0, polls, port);
    checkOutput("bp_pending_interval", polls, 0);

    // Reset lands in the middle of a multiply's execute window
    applyStimulus(1, 3'b101, 16'd1234, 16'd77);
    #1;
    checkOutput("rstmid_grant", {31'd0, req1_ready}, 1);
    @(posedge clk); #1 req1_valid = 1'b0;
    @(posedge clk); #2 reset = 1'b1;
    #1;
    checkOutput("rstmid_ctrl", {28'd0, busy, rsp_valid, rsp_id, rsp_zero}, 0);
    checkOutput("rstmid_alu", {13'd0, alu_control, alu_in1}, 0);
    checkOutput("rstmid_res", {alu_in2, rsp_res}, 0);
    lastGrant = 1;
    @(negedge clk); reset = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      checkOutput("rstmid_no_stale", {30'd0, rsp_valid, busy}, 0);
    end
    applyStimulus(0, 3'b001, 16'd10, 16'd4);
    applyStimulus(1, 3'b000, 16'd10, 16'd4);
    serveOne("post_reset", 1'b0, 0, polls, port);
    checkOutput("post_reset_port0_first", port, 0);
    serveOne("post_reset2", 1'b0, 0, polls, port);

    for (int n = 0; n < 40; n++) begin
      int bp;
      if (!req0_valid && $urandom_range(0, 1) == 1)
        applyStimulus(0, 3'($urandom_range(0, 7)), 16'($urandom), 16'($urandom));
      if (!req1_valid && $urandom_range(0, 1) == 1)
        applyStimulus(1, 3'($urandom_range(0, 7)), 16'($urandom), 16'($urandom));
      if (!req0_valid && !req1_valid)
        applyStimulus(0, 3'($urandom_range(0, 7)), 16'($urandom), 16'($urandom));
      bp = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
      if (bp > 0) rsp_ready = 1'b0;
      serveOne("random", 1'b0, bp, polls, port);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
